id_issue_scoreboard: RTL and testbench
======================================

// Module: id_issue_scoreboard
// PURPOSE
//  Issue controller between decode (ID) and EX. Tracks in-flight register writes per GPR.
//  Holds an instruction in ID until every source it reads has retired, since the regfile
//  has no forwarding. Enforces a global in-flight write limit.
//  Sequences the fetch flush that follows a taken jump/branch redirect (mux_pc).
// PARAMETERS
//  MAX_INFLIGHT  4  global limit on outstanding (issued, not written back) register writes; 1..7
//  FLUSH_CYCLES  1  cycles flush_if stays high after a redirect issues; 1..3
//  CNT_W         2  width of each per-register pending counter (max 2^CNT_W-1 per reg)
// PORTS
//  clock         in   1  system clock, rising edge
//  reset         in   1  asynchronous, active-low reset
//  id_valid      in   1  ID holds a valid decoded instruction
//  id_r_ena1     in   1  instruction reads rs1
//  id_r_addr1    in   5  rs1 index
//  id_r_ena2     in   1  instruction reads rs2
//  id_r_addr2    in   5  rs2 index
//  id_w_ena      in   1  instruction writes rd
//  id_w_addr     in   5  rd index
//  id_jump       in   1  instruction redirects PC (decoder jump / mux_pc)
//  ex_ready      in   1  EX can accept an instruction this cycle
//  wb_ena        in   1  regfile write (retire) this cycle
//  wb_addr       in   5  retiring rd index
//  issue         out  1  instruction moves ID->EX at this clock edge
//  stall_if      out  1  hold PC and the IF/ID register
//  flush_if      out  1  kill the instruction currently in IF/ID
//  busy          out  1  any write in flight (pend_cnt != 0)
//  pend_cnt      out  3  number of outstanding writes
//  err           out  1  sticky: retire seen for a register with zero pending count
// BEHAVIOUR
//  Reset (reset=0, async): all pending counters=0, pend_cnt=0, state=RUN, flush counter=0.
//    Outputs issue=0, stall_if=0, flush_if=0, busy=0, err=0.
//    A reset mid-operation discards all in-flight tracking immediately.
//  x0 is never tracked. Reads of x0 never hazard. Writes and retires of x0 change no counter.
//  hazard = (id_r_ena1 & addr1!=0 & pend[addr1]!=0) | (id_r_ena2 & addr2!=0 & pend[addr2]!=0).
//  Hazard uses the registered counters only. A retire in the same cycle does not unblock a read:
//    the regfile write lands at the edge, so the read may issue no earlier than the next cycle.
//  full = id_w_ena & id_w_addr!=0 & (pend_cnt==MAX_INFLIGHT | pend[id_w_addr]==2^CNT_W-1).
//  issue = (state==RUN) & id_valid & ex_ready & ~hazard & ~full  (combinational, zero latency).
//  stall_if = (state==RUN) & id_valid & ~issue.  flush_if = (state==FLUSH).
//  Counter update per edge:
//    inc when issue & id_w_ena & rd!=0; dec when wb_ena & wb_addr!=0 & pend[wb_addr]!=0.
//    Same register inc+dec together: counter unchanged, pend_cnt unchanged.
//    Different registers: each counter updates; pend_cnt = pend_cnt + inc - dec.
//  Retire to a register whose counter is 0: counter stays 0, pend_cnt unchanged, err<=1.
//    err clears only on reset.
//  FSM states: RUN, FLUSH.
//    RUN -> FLUSH when issue & id_jump. Load flush counter with FLUSH_CYCLES-1.
//    FLUSH: issue=0, stall_if=0, flush_if=1. Retires are still processed.
//    Counter decrements each cycle; FLUSH -> RUN when the counter is 0.
//    The jump's own rd write is tracked like any other write.
//  A jump blocked by hazard/full/~ex_ready does not redirect. No flush until it issues.
//  busy = (pend_cnt != 0). pend_cnt never exceeds MAX_INFLIGHT.
// TESTING
//  1 Reset: reset=0 during traffic, pend[5]=2
//    -> next sample: pend_cnt=0, busy=0, issue=0, flush_if=0, err=0.
//  2 RAW: issue rd=x5, then id reads rs1=x5
//    -> stall_if=1, issue=0 until wb_ena/wb_addr=5; issue=1 on the cycle after wb, not the wb cycle.
//  3 x0: issue rd=x0, then read rs1=x0, rs2=x0 -> no stall, pend_cnt stays 0.
//    wb_addr=0 -> err stays 0.
//  4 Simultaneous: pend[7]=1; issue rd=x7 with wb_ena, wb_addr=7 -> pend[7]=1, pend_cnt unchanged.
//  5 Redirect, FLUSH_CYCLES=2: issue with id_jump=1 -> flush_if=1 for exactly 2 cycles.
//    issue=0 during them despite id_valid=ex_ready=1; normal issue on the 3rd cycle.
//  6 Limit, MAX_INFLIGHT=4: issue writes x1..x4, then a 5th write x6 -> stall_if=1, pend_cnt=4.
//    wb x1 -> the 5th issues next cycle. Then wb x9 (count 0) -> err=1, pend_cnt unchanged.

Source files
------------

// File: rtl/id_issue_scoreboard.sv
// ID->EX issue control: per-GPR pending-write scoreboard, global
// in-flight limit and post-redirect fetch flush sequencing.
module id_issue_scoreboard #(
    parameter int MAX_INFLIGHT = 4,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       id_valid,
    input  logic       id_r_ena1,
    input  logic [4:0] id_r_addr1,
    input  logic       id_r_ena2,
    input  logic [4:0] id_r_addr2,
    input  logic       id_w_ena,
    input  logic [4:0] id_w_addr,
    input  logic       id_jump,
    input  logic       ex_ready,
    input  logic       wb_ena,
    input  logic [4:0] wb_addr,
    output logic       issue,
    output logic       stall_if,
    output logic       flush_if,
    output logic       busy,
    output logic [2:0] pend_cnt,
    output logic       err
);

    typedef enum logic {RUN, FLUSH} state_e;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [2:0]       LIMIT    = 3'(MAX_INFLIGHT);
    localparam logic [1:0]       FLUSH_LD = 2'(FLUSH_CYCLES - 1);

    state_e           state_q, state_d;
    logic [1:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0] pend_q [32];
    logic [CNT_W-1:0] pend_d [32];
    logic [2:0]       cnt_q, cnt_d;
    logic             err_q, err_d;

    logic hazard, full, run, inc, ret, dec;

    // Registered counters only: a same-cycle retire does not unblock a read.
    always_comb begin
        hazard = (id_r_ena1 && id_r_addr1 != 5'd0 && pend_q[id_r_addr1] != '0)
              || (id_r_ena2 && id_r_addr2 != 5'd0 && pend_q[id_r_addr2] != '0);
        full   = id_w_ena && id_w_addr != 5'd0
              && (cnt_q == LIMIT || pend_q[id_w_addr] == CNT_MAX);
        run    = reset && state_q == RUN;
        issue  = run && id_valid && ex_ready && !hazard && !full;
        stall_if = run && id_valid && !issue;
        flush_if = state_q == FLUSH;
    end

    always_comb begin
        inc    = issue && id_w_ena && id_w_addr != 5'd0;
        ret    = wb_ena && wb_addr != 5'd0;
        dec    = ret && pend_q[wb_addr] != '0;
        pend_d = pend_q;
        cnt_d  = cnt_q;
        err_d  = err_q || (ret && pend_q[wb_addr] == '0);
        if (!(inc && dec && id_w_addr == wb_addr)) begin
            if (inc) pend_d[id_w_addr] = pend_q[id_w_addr] + 1'b1;
            if (dec) pend_d[wb_addr] = pend_q[wb_addr] - 1'b1;
        end
        if (inc && !dec) cnt_d = cnt_q + 3'd1;
        if (dec && !inc) cnt_d = cnt_q - 3'd1;
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            RUN: begin
                if (issue && id_jump) begin
                    state_d = FLUSH;
                    fcnt_d  = FLUSH_LD;
                end
            end
            FLUSH: begin
                if (fcnt_q == 2'd0) state_d = RUN;
                else fcnt_d = fcnt_q - 2'd1;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            fcnt_q  <= 2'd0;
            cnt_q   <= 3'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < 32; i++) pend_q[i] <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            for (int i = 0; i < 32; i++) pend_q[i] <= pend_d[i];
        end
    end

    assign busy     = cnt_q != 3'd0;
    assign pend_cnt = cnt_q;
    assign err      = err_q;

endmodule

// File: tb/tb_id_issue_scoreboard.sv
// Randomized and directed bench for id_issue_scoreboard against a
// queue-of-outstanding-writes reference model.
module tb_id_issue_scoreboard;

    localparam int MAXF = 4;
    localparam int FLC  = 2;
    localparam int CW   = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       id_valid = 0, id_r_ena1 = 0, id_r_ena2 = 0;
    logic       id_w_ena = 0, id_jump = 0, ex_ready = 0, wb_ena = 0;
    logic [4:0] id_r_addr1 = 0, id_r_addr2 = 0, id_w_addr = 0, wb_addr = 0;
    logic       issue, stall_if, flush_if, busy, err;
    logic [2:0] pend_cnt;

    int total = 0;
    int bad   = 0;

    logic [4:0] inflight [$];
    bit         m_err;
    int         flush_left;

    id_issue_scoreboard #(
        .MAX_INFLIGHT(MAXF),
        .FLUSH_CYCLES(FLC),
        .CNT_W(CW)
    ) dut (
        .clock(clock), .reset(reset),
        .id_valid(id_valid),
        .id_r_ena1(id_r_ena1), .id_r_addr1(id_r_addr1),
        .id_r_ena2(id_r_ena2), .id_r_addr2(id_r_addr2),
        .id_w_ena(id_w_ena), .id_w_addr(id_w_addr),
        .id_jump(id_jump), .ex_ready(ex_ready),
        .wb_ena(wb_ena), .wb_addr(wb_addr),
        .issue(issue), .stall_if(stall_if), .flush_if(flush_if),
        .busy(busy), .pend_cnt(pend_cnt), .err(err)
    );

    always #5 clock = ~clock;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int outstanding(logic [4:0] r);
        int n = 0;
        foreach (inflight[i]) if (inflight[i] == r) n++;
        return n;
    endfunction

    task automatic set_in(bit v, bit e1, logic [4:0] a1, bit e2,
                          logic [4:0] a2, bit we, logic [4:0] wa,
                          bit j, bit rdy, bit wbe, logic [4:0] wba);
        id_valid = v; id_r_ena1 = e1; id_r_addr1 = a1;
        id_r_ena2 = e2; id_r_addr2 = a2;
        id_w_ena = we; id_w_addr = wa; id_jump = j;
        ex_ready = rdy; wb_ena = wbe; wb_addr = wba;
    endtask

    // Check all outputs against the model, then clock one edge.
    task automatic cyc();
        bit hz, fl, iss;
        int k;
        #1;
        hz = (id_r_ena1 && id_r_addr1 != 0 && outstanding(id_r_addr1) > 0)
          || (id_r_ena2 && id_r_addr2 != 0 && outstanding(id_r_addr2) > 0);
        fl = id_w_ena && id_w_addr != 0
          && (inflight.size() == MAXF || outstanding(id_w_addr) == (1 << CW) - 1);
        iss = flush_left == 0 && id_valid && ex_ready && !hz && !fl;
        chk("issue", issue, iss);
        chk("stall_if", stall_if, flush_left == 0 && id_valid && !iss);
        chk("flush_if", flush_if, flush_left > 0);
        chk("pend_cnt", pend_cnt, inflight.size());
        chk("busy", busy, inflight.size() != 0);
        chk("err", err, m_err);
        @(posedge clock);
        if (flush_left > 0) flush_left--;
        else if (iss && id_jump) flush_left = FLC;
        if (wb_ena && wb_addr != 0) begin
            k = -1;
            foreach (inflight[i]) if (k < 0 && inflight[i] == wb_addr) k = i;
            if (k >= 0) inflight.delete(k);
            else m_err = 1;
        end
        if (iss && id_w_ena && id_w_addr != 0) inflight.push_back(id_w_addr);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_pend_cnt", pend_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_issue", issue, 0);
        chk("rst_stall", stall_if, 0);
        chk("rst_flush", flush_if, 0);
        chk("rst_err", err, 0);
        inflight.delete();
        m_err = 0;
        flush_left = 0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        m_err = 0;
        flush_left = 0;
        @(negedge clock);
        do_reset();

        // x0 never tracked
        set_in(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0); cyc();
        set_in(1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0); cyc();
        chk("x0_cnt", pend_cnt, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); cyc();
        chk("x0_err", err, 0);

        // RAW on x5: held through the wb cycle, issues the cycle after
        set_in(1, 0, 0, 0, 0, 1, 5, 0, 1, 0, 0); cyc();
        set_in(1, 1, 5, 0, 0, 0, 0, 0, 1, 0, 0); cyc(); cyc();
        chk("raw_stall", stall_if, 1);
        set_in(1, 1, 5, 0, 0, 0, 0, 0, 1, 1, 5);
        #1 chk("raw_wb_cycle", issue, 0);
        cyc();
        set_in(1, 1, 5, 0, 0, 0, 0, 0, 1, 0, 0);
        #1 chk("raw_after_wb", issue, 1);
        cyc();

        // simultaneous issue and retire of x7
        set_in(1, 0, 0, 0, 0, 1, 7, 0, 1, 0, 0); cyc();
        set_in(1, 0, 0, 0, 0, 1, 7, 0, 1, 1, 7); cyc();
        chk("simul_cnt", pend_cnt, 1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7); cyc();

        // redirect with two flush cycles
        set_in(1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0); cyc();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        #1 chk("flush_c1", flush_if, 1);
        chk("flush_c1_iss", issue, 0);
        cyc();
        #1 chk("flush_c2", flush_if, 1);
        cyc();
        #1 chk("flush_done", flush_if, 0);
        chk("run_issue", issue, 1);
        cyc();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1); cyc();

        // global limit
        for (int r = 1; r <= 4; r++) begin
            set_in(1, 0, 0, 0, 0, 1, 5'(r), 0, 1, 0, 0); cyc();
        end
        set_in(1, 0, 0, 0, 0, 1, 6, 0, 1, 0, 0);
        #1 chk("limit_stall", stall_if, 1);
        chk("limit_cnt", pend_cnt, 4);
        cyc();
        set_in(1, 0, 0, 0, 0, 1, 6, 0, 1, 1, 1);
        #1 chk("limit_wb_cycle", issue, 0);
        cyc();
        set_in(1, 0, 0, 0, 0, 1, 6, 0, 1, 0, 0);
        #1 chk("limit_issue", issue, 1);
        cyc();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9); cyc();
        chk("err_set", err, 1);
        chk("err_cnt", pend_cnt, 4);

        // reset during traffic with two writes pending on x5
        do_reset();
        set_in(1, 0, 0, 0, 0, 1, 5, 0, 1, 0, 0); cyc(); cyc();
        chk("pre_rst_cnt", pend_cnt, 2);
        set_in(1, 1, 5, 0, 0, 1, 3, 0, 1, 0, 0);
        do_reset();

        for (int i = 0; i < 600; i++) begin
            bit wbe;
            logic [4:0] wba;
            wbe = 0;
            wba = 0;
            if (inflight.size() > 0 && $urandom_range(2) == 0) begin
                wbe = 1;
                wba = inflight[$urandom_range(inflight.size() - 1)];
            end else if ($urandom_range(60) == 0) begin
                wbe = 1;
                wba = 5'($urandom_range(7));
            end
            set_in($urandom_range(3) != 0,
                   1'($urandom), 5'($urandom_range(7)),
                   1'($urandom), 5'($urandom_range(7)),
                   1'($urandom), 5'($urandom_range(7)),
                   $urandom_range(7) == 0, $urandom_range(3) != 0,
                   wbe, wba);
            cyc();
            if (i == 300) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
